// File: rtl/ro_freq_meter_pkg.sv
// Shared types and default parameters for the ring-oscillator frequency meter.
package ro_freq_meter_pkg;

    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_WIN_W       = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATE   = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/ro_freq_meter_if.sv
// Request/result bundle between a measurement requester (master) and the meter (slave).
interface ro_freq_meter_if #(
    parameter int unsigned CNT_W = ro_freq_meter_pkg::DEF_CNT_W,
    parameter int unsigned WIN_W = ro_freq_meter_pkg::DEF_WIN_W
);
    logic             start;
    logic [WIN_W-1:0] window_len;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output start, window_len,
        input  busy, done, count, overflow
    );

    modport slave (
        input  start, window_len,
        output busy, done, count, overflow
    );
endinterface

// File: rtl/ro_freq_meter_edge_sync.sv
// Synchronizes the asynchronous oscillator input and flags its rising edges.
module ro_edge_sync
    import ro_freq_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic osc_in,
    output logic edge_p
);

    if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_stages
        $error("ro_edge_sync: SYNC_STAGES out of range");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_p = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Counts ring-oscillator rising edges over a programmable clk-cycle gate window.
// RO_FREQ_CONTINUOUS_EN: REPORT re-arms GATE with the last captured window length.
module ro_freq_meter
    import ro_freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned WIN_W       = DEF_WIN_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            osc_in,
    ro_freq_meter_if.slave  bus
);

    logic             edge_p;
    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
`ifdef RO_FREQ_CONTINUOUS_EN
    logic [WIN_W-1:0] win_len_q, win_len_d;
`endif

    ro_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_in),
        .edge_p (edge_p)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef RO_FREQ_CONTINUOUS_EN
            win_len_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef RO_FREQ_CONTINUOUS_EN
            win_len_q  <= win_len_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
`ifdef RO_FREQ_CONTINUOUS_EN
        win_len_d  = win_len_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    win_cnt_d  = bus.window_len;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
`ifdef RO_FREQ_CONTINUOUS_EN
                    win_len_d  = bus.window_len;
`endif
                    if (bus.window_len == '0) begin
                        state_d    = ST_REPORT;
                        count_d    = '0;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = ST_GATE;
                    end
                end
            end
            ST_GATE: begin
                if (edge_p) begin
                    if (edge_cnt_q == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end
                win_cnt_d = win_cnt_q - WIN_W'(1);
                // Results take the final cycle's edge into account.
                if (win_cnt_q == WIN_W'(1)) begin
                    state_d    = ST_REPORT;
                    count_d    = edge_cnt_d;
                    overflow_d = ovf_d;
                end
            end
            ST_REPORT: begin
`ifdef RO_FREQ_CONTINUOUS_EN
                win_cnt_d  = win_len_q;
                edge_cnt_d = '0;
                ovf_d      = 1'b0;
                state_d    = (win_len_q == '0) ? ST_REPORT : ST_GATE;
`else
                state_d    = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_REPORT);
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Self-checking bench for ro_freq_meter: scoreboard of expected window results.
module tb_ro_freq_meter;

    typedef struct {
        int lat;
        int cmin;
        int cmax;
        bit ovf;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic osc_in = 1'b0;

    int checks = 0;
    int errors = 0;
    exp_t sbq[$];

    int osc_per = 0;
    int osc_hi  = 0;
    int osc_ph  = 0;
    bit osc_lvl = 1'b0;

    always #5 clk = ~clk;

    ro_freq_meter_if #(.CNT_W(16), .WIN_W(16)) bus ();
    ro_freq_meter_if #(.CNT_W(4),  .WIN_W(16)) bus4 ();

    ro_freq_meter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_in),
        .bus    (bus)
    );

    ro_freq_meter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(3)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_in),
        .bus    (bus4)
    );

    // Oscillator stand-in: period/high in clk cycles, or a static level when period is 0.
    initial begin
        forever begin
            @(negedge clk);
            if (osc_per == 0) begin
                osc_in = osc_lvl;
            end else begin
                osc_in = (osc_ph < osc_hi);
                osc_ph = (osc_ph + 1) % osc_per;
            end
        end
    end

    task automatic set_osc(input int per, input int hi, input bit lvl);
        osc_per = per;
        osc_hi  = hi;
        osc_lvl = lvl;
        osc_ph  = 0;
    endtask

    task automatic wait_done(input bit sel4, input int limit, output int lat, output logic busy1);
        lat   = -1;
        busy1 = 1'bx;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (n == 1) begin
                if (sel4) begin
                    bus4.start = 1'b0;
                    busy1 = bus4.busy;
                end else begin
                    bus.start = 1'b0;
                    busy1 = bus.busy;
                end
            end
            if ((sel4 ? bus4.done : bus.done) === 1'b1) begin
                lat = n;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 16'd0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b count=%0d ovf=%b exp 0/0/0/0",
                     bus.busy, bus.done, bus.count, bus.overflow);
        end
        checks++;
        if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.count !== 4'd0 || bus4.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs4 got busy=%b done=%b count=%0d ovf=%b exp 0/0/0/0",
                     bus4.busy, bus4.done, bus4.count, bus4.overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_quarter_rate();
        int lat;
        logic b1;
        exp_t e;
        set_osc(4, 2, 1'b0);
        repeat (8) @(negedge clk);
        sbq.push_back('{lat: 101, cmin: 24, cmax: 26, ovf: 1'b0});
        bus.window_len = 16'd100;
        bus.start = 1'b1;
        wait_done(1'b0, 200, lat, b1);
        e = sbq.pop_front();
        checks++;
        if (b1 !== 1'b1) begin errors++; $display("FAIL quarter_busy got %b exp 1", b1); end
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL quarter_lat got %0d exp %0d", lat, e.lat); end
        checks++;
        if (int'(bus.count) < e.cmin || int'(bus.count) > e.cmax) begin
            errors++; $display("FAIL quarter_count got %0d exp %0d..%0d", bus.count, e.cmin, e.cmax);
        end
        checks++;
        if (bus.overflow !== e.ovf) begin errors++; $display("FAIL quarter_ovf got %b exp %b", bus.overflow, e.ovf); end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL quarter_after got done=%b busy=%b exp 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_static_level();
        int lat;
        logic b1;
        exp_t e;
        set_osc(0, 0, 1'b0);
        repeat (6) @(negedge clk);
        sbq.push_back('{lat: 51, cmin: 0, cmax: 0, ovf: 1'b0});
        bus.window_len = 16'd50;
        bus.start = 1'b1;
        wait_done(1'b0, 100, lat, b1);
        e = sbq.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL low_lat got %0d exp %0d", lat, e.lat); end
        checks++;
        if (int'(bus.count) < e.cmin || int'(bus.count) > e.cmax) begin
            errors++; $display("FAIL low_count got %0d exp %0d..%0d", bus.count, e.cmin, e.cmax);
        end
        @(negedge clk);
        set_osc(0, 0, 1'b1);
        sbq.push_back('{lat: 51, cmin: 0, cmax: 1, ovf: 1'b0});
        bus.window_len = 16'd50;
        bus.start = 1'b1;
        wait_done(1'b0, 100, lat, b1);
        e = sbq.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL high_lat got %0d exp %0d", lat, e.lat); end
        checks++;
        if (int'(bus.count) < e.cmin || int'(bus.count) > e.cmax) begin
            errors++; $display("FAIL high_count got %0d exp %0d..%0d", bus.count, e.cmin, e.cmax);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        int lat;
        logic b1;
        exp_t e;
        set_osc(4, 2, 1'b0);
        repeat (4) @(negedge clk);
        sbq.push_back('{lat: 1, cmin: 0, cmax: 0, ovf: 1'b0});
        bus.window_len = 16'd0;
        bus.start = 1'b1;
        wait_done(1'b0, 10, lat, b1);
        e = sbq.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL zero_lat got %0d exp %0d", lat, e.lat); end
        checks++;
        if (b1 !== 1'b1) begin errors++; $display("FAIL zero_busy got %b exp 1", b1); end
        checks++;
        if (int'(bus.count) != e.cmin) begin errors++; $display("FAIL zero_count got %0d exp %0d", bus.count, e.cmin); end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL zero_after got busy=%b done=%b exp 0/0", bus.busy, bus.done);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic b1;
        exp_t e;
        set_osc(3, 1, 1'b0);
        repeat (6) @(negedge clk);
        sbq.push_back('{lat: 65, cmin: 15, cmax: 15, ovf: 1'b1});
        sbq.push_back('{lat: 7, cmin: 1, cmax: 3, ovf: 1'b0});
        for (int w = 0; w < 2; w++) begin
            bus4.window_len = (w == 0) ? 16'd64 : 16'd6;
            bus4.start = 1'b1;
            wait_done(1'b1, 120, lat, b1);
            e = sbq.pop_front();
            checks++;
            if (lat !== e.lat) begin errors++; $display("FAIL ovf_lat[%0d] got %0d exp %0d", w, lat, e.lat); end
            checks++;
            if (int'(bus4.count) < e.cmin || int'(bus4.count) > e.cmax) begin
                errors++; $display("FAIL ovf_count[%0d] got %0d exp %0d..%0d", w, bus4.count, e.cmin, e.cmax);
            end
            checks++;
            if (bus4.overflow !== e.ovf) begin
                errors++; $display("FAIL ovf_flag[%0d] got %b exp %b", w, bus4.overflow, e.ovf);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        int first_lat;
        int ndone;
        exp_t e;
        set_osc(4, 2, 1'b0);
        repeat (4) @(negedge clk);
        sbq.push_back('{lat: 41, cmin: 9, cmax: 11, ovf: 1'b0});
        bus.window_len = 16'd40;
        bus.start = 1'b1;
        first_lat = -1;
        ndone = 0;
        e = sbq.pop_front();
        for (int n = 1; n <= 90; n++) begin
            @(negedge clk);
            if (n == 1)  bus.start = 1'b0;
            if (n == 10) begin bus.start = 1'b1; bus.window_len = 16'd5; end
            if (n == 11) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                ndone++;
                if (first_lat < 0) begin
                    first_lat = n;
                    checks++;
                    if (int'(bus.count) < e.cmin || int'(bus.count) > e.cmax) begin
                        errors++; $display("FAIL ignore_count got %0d exp %0d..%0d", bus.count, e.cmin, e.cmax);
                    end
                end
            end
        end
        checks++;
        if (first_lat !== e.lat) begin errors++; $display("FAIL ignore_lat got %0d exp %0d", first_lat, e.lat); end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL ignore_ndone got %0d exp 1", ndone); end
    endtask

    task automatic test_reset_mid_gate();
        int ndone;
        logic prev_busy;
        bus.window_len = 16'd30;
        bus.start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
        end
        prev_busy = bus.busy;
        checks++;
        if (prev_busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b exp 1", prev_busy); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 16'd0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got busy=%b done=%b count=%0d ovf=%b exp 0/0/0/0",
                     bus.busy, bus.done, bus.count, bus.overflow);
        end
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", ndone); end
    endtask

`ifdef RO_FREQ_CONTINUOUS_EN
    task automatic test_continuous();
        int seen;
        exp_t e;
        set_osc(4, 2, 1'b0);
        repeat (4) @(negedge clk);
        for (int k = 1; k <= 3; k++) sbq.push_back('{lat: 8 * k, cmin: 1, cmax: 2, ovf: 1'b0});
        bus.window_len = 16'd7;
        bus.start = 1'b1;
        seen = 0;
        for (int n = 1; n <= 26 && seen < 3; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                seen++;
                e = sbq.pop_front();
                checks++;
                if (n !== e.lat) begin errors++; $display("FAIL cont_lat[%0d] got %0d exp %0d", seen, n, e.lat); end
                checks++;
                if (int'(bus.count) < e.cmin || int'(bus.count) > e.cmax) begin
                    errors++; $display("FAIL cont_count[%0d] got %0d exp %0d..%0d", seen, bus.count, e.cmin, e.cmax);
                end
            end
        end
        checks++;
        if (seen !== 3) begin errors++; $display("FAIL cont_ndone got %0d exp 3", seen); end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL cont_busy got %b exp 1", bus.busy); end
        sbq.delete();
    endtask
`endif

    initial begin
        bus.start       = 1'b0;
        bus.window_len  = '0;
        bus4.start      = 1'b0;
        bus4.window_len = '0;
        test_reset();
`ifdef RO_FREQ_CONTINUOUS_EN
        test_continuous();
        test_reset_mid_gate();
`else
        test_quarter_rate();
        test_static_level();
        test_zero_len();
        test_overflow();
        test_start_ignored();
        test_reset_mid_gate();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ro_freq_meter.md
# ro_freq_meter

Measures the frequency of the on-chip ring oscillator output by counting its rising edges during a gate window of a programmable number of system-clock cycles. It is the consumer at the far end of the oscillator's output net. It sits beside the oscillator in the top-level wrapper, and its result is exposed on the dedicated outputs for bring-up and characterization.

## Interface
- `CNT_W`, default 16: edge-count width; result saturates at 2^CNT_W−1.
- `WIN_W`, default 16: gate-window length width.
- `SYNC_STAGES`, default 2: synchronizer depth for `osc_in`; legal values are 2–3.

Ports:
- `clk`  in  1: system clock; all logic is on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `osc_in`  in  1: ring-oscillator output, asynchronous to `clk`.
- `start`  in  WIN_W? no, 1: request one measurement; sampled only in IDLE.
- `window_len`  in  WIN_W: gate length in `clk` cycles; captured when `start` is accepted.
- `busy`  out  1: high in GATE and REPORT.
- `done`  out  1: one-cycle pulse; `count` and `overflow` are valid from this cycle on.
- `count`  out  CNT_W: rising edges seen in the last window; held until the next REPORT.
- `overflow`  out  1: the edge counter saturated during the last window; held alongside `count`.

## Operation
- **Synchronizer and edge detect.** `osc_in` passes through `SYNC_STAGES` flops, then one history flop.
  - `edge_p` = synced & ~history.
  - Only synchronized edges are counted. The result is correct only for f_osc < f_clk/2.
  - Faster oscillators alias; this is a documented limitation, not a detected error.
- **IDLE** (reset state).
  - `start`=1 → GATE. `win_cnt` ← `window_len`, `edge_cnt` ← 0, `ovf_int` ← 0.
  - If `window_len`=0 → go straight to REPORT instead, with `edge_cnt`=0.
- **GATE.**
  - Each cycle with `edge_p`: `edge_cnt` increments. At 2^CNT_W−1 it holds and sets `ovf_int`.
  - `win_cnt` decrements every cycle.
  - In the cycle where `win_cnt`=1, including that cycle's `edge_p`, → REPORT.
  - GATE therefore lasts exactly `window_len` cycles.
- **REPORT** (one cycle).
  - `done`=1. `count` ← final `edge_cnt`, `overflow` ← `ovf_int` (registered on entry, visible this cycle).
  - Then → IDLE.
- `start` in GATE or REPORT is ignored, not queued.
- `window_len` changes after acceptance have no effect on the current window.
- The synchronizer and history flops run in every state, so no stale edge is counted at GATE entry.
- **Reset mid-operation:** the synchronous reset aborts the window and forces all outputs to reset values at the next edge. No `done` is issued.

## Timing
- Reset values: `busy`=0, `done`=0, `count`=0, `overflow`=0, state IDLE, all flops 0.
- `start` accepted in cycle T → `busy`=1 at T+1.
- `done` pulses at T+1+`window_len`, and at T+1 when `window_len`=0.
- `busy` falls the cycle after `done`. The earliest next `start` acceptance is the cycle `busy` is 0.
- Edge latency from `osc_in` to counting is SYNC_STAGES+1 cycles. The window therefore covers `osc_in` activity shifted by that amount; no compensation is applied.
- `count` and `overflow` change only in the REPORT cycle or on reset.

## Configuration
- `RO_FREQ_CONTINUOUS_EN` defined:
  - REPORT returns to GATE instead of IDLE, reloading the last captured `window_len` and clearing `edge_cnt` and `ovf_int`.
  - This gives back-to-back windows with no dead cycles except REPORT.
  - `busy` stays high until reset.
  - `start` is still needed for the first window.
  - `window_len`=0 in this mode yields `done` every cycle with `count`=0.
- Not defined: single-shot as described under Operation.

## Structure
- Package `ro_freq_meter_pkg`:
  - state enum (IDLE, GATE, REPORT);
  - default `CNT_W`/`WIN_W`/`SYNC_STAGES` constants;
  - `SYNC_STAGES` legal-range constants.
- Sub-module `ro_edge_sync`: synchronizer chain, history flop, `edge_p` output, reset to 0.
- Everything else (FSM, window and edge counters, result registers) lives in `ro_freq_meter`.

## Test plan
- `osc_in` square wave at f_clk/4 (2 high, 2 low), `window_len`=100, `start` pulse → `done` at T+101, `count`=25±1, `overflow`=0.
- `osc_in` held 0, `window_len`=50 → `done` at T+51, `count`=0; a second start with `osc_in`=1 constant → `count`≤1.
- `window_len`=0 → `done` at T+1, `count`=0, `busy` high only in that cycle.
- `CNT_W`=4, `osc_in` at f_clk/3, `window_len`=64 → `count`=15, `overflow`=1; the next window of length 6 → `count`=2±1, `overflow`=0.
- `start` pulsed again mid-GATE, and `window_len` changed mid-GATE → a single `done` at the originally scheduled cycle, unaffected count.
- `rst_n` low for 1 cycle mid-GATE → next cycle `busy`=0, `count`=0, no `done`. With `RO_FREQ_CONTINUOUS_EN`: three consecutive `done` pulses spaced `window_len`+1 cycles apart.
